// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg
//   Shared widths and the state encoding for the mantissa normalizer that
//   sits behind the 24-bit mantissa adder of the floating-point add path.
//   Optional macro: NORM_ROUND_EN adds the ROUND state used for
//   round-to-nearest-even on the carry (right shift) path.
package fp_norm_pkg;

  localparam int MANT_W  = 24;                 // mantissa / adder sum width
  localparam int EXP_W   = 8;                  // biased exponent width
  localparam int EXP_MAX = (1 << EXP_W) - 1;   // all-ones exponent = overflow

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SHIFT,
    ST_DONE
`ifdef NORM_ROUND_EN
    , ST_ROUND
`endif
  } norm_state_e;

endpackage

// File: rtl/fp_mant_normalize.sv
// fp_mant_normalize
//   Iterative normalizer for the adder result. A word is accepted in IDLE,
//   classified in CHECK (carry / zero / already normalized / needs shifting),
//   shifted left one bit per cycle in SHIFT, and held in DONE until taken.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready high only in IDLE
//   in_mant/in_carry     adder sum and carry-out
//   in_exp               biased exponent of the larger operand
//   out_valid/out_ready  output handshake; outputs frozen while waiting
//   out_mant/out_exp     normalized mantissa and adjusted exponent
//   out_zero/ovf/unf     exact zero, exponent overflow, underflow (exclusive)
//
// Optional macro: NORM_ROUND_EN -- on the carry path the bit shifted out is
//   kept as a guard bit and rounded (nearest-even) in an extra ROUND cycle.
//   Without it the bit is truncated.
module fp_mant_normalize
  import fp_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_carry,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam logic [MANT_W-1:0] MANT_MSB  = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [EXP_W:0]    EXP_MAX_X = (EXP_W+1)'(EXP_MAX);
  localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);

  norm_state_e       state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [EXP_W:0]    exp_inc;
`ifdef NORM_ROUND_EN
  localparam logic [MANT_W-1:0] MANT_ONE = MANT_W'(1);
  logic              guard_q, guard_d;
`endif

  // One extra bit so the overflow compare cannot be fooled by wrap-around.
  assign exp_inc = {1'b0, exp_q} + (EXP_W+1)'(1);

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`ifdef NORM_ROUND_EN
    guard_d = guard_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mant_d  = in_mant;
          carry_d = in_carry;
          exp_d   = in_exp;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (carry_q) begin
          carry_d = 1'b0;
          if (exp_inc >= EXP_MAX_X) begin
            ovf_d   = 1'b1;
            mant_d  = '0;
            exp_d   = EXP_W'(EXP_MAX);
            state_d = ST_DONE;
          end else begin
            mant_d  = {1'b1, mant_q[MANT_W-1:1]};
            exp_d   = exp_inc[EXP_W-1:0];
`ifdef NORM_ROUND_EN
            guard_d = mant_q[0];
            state_d = ST_ROUND;
`else
            state_d = ST_DONE;
`endif
          end
        end else if (mant_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          state_d = ST_DONE;
        end else if (mant_q[MANT_W-1]) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (mant_q[MANT_W-1]) begin
          state_d = ST_DONE;
        end else if (exp_q > EXP_ONE) begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
          // Look ahead: if this shift brings the leading one to the top,
          // finish now so k shifts cost exactly k cycles.
          if (mant_q[MANT_W-2]) begin
            state_d = ST_DONE;
          end
        end else begin
          unf_d   = 1'b1;
          exp_d   = '0;
          state_d = ST_DONE;
        end
      end
`ifdef NORM_ROUND_EN
      ST_ROUND: begin
        // exp_q already holds the carry-adjusted exponent here.
        if (guard_q && mant_q[0]) begin
          if (&mant_q) begin
            if (exp_inc >= EXP_MAX_X) begin
              ovf_d  = 1'b1;
              mant_d = '0;
              exp_d  = EXP_W'(EXP_MAX);
            end else begin
              mant_d = MANT_MSB;
              exp_d  = exp_inc[EXP_W-1:0];
            end
          end else begin
            mant_d = mant_q + MANT_ONE;
          end
        end
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef NORM_ROUND_EN
      guard_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef NORM_ROUND_EN
      guard_q <= guard_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp_mant_normalize.sv
module tb_fp_mant_normalize;
  import fp_norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_mant = '0;
  logic        in_carry = 1'b0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero, out_ovf, out_unf;

  fp_mant_normalize dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_carry(in_carry), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] m;
    logic [7:0]  e;
    bit          z, o, u;
    int          lat;   // out_valid first seen at accept edge + lat
    int          acc;   // cycle count right after the accept edge
  } res_t;

  res_t        q[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          started = 0;
  bit          in_done = 0;
  int          vcnt = 0;
  int          first_lat = 0;
  int          hold_cnt = 0;
  logic [23:0] last_m = '0;
  logic [7:0]  last_e = '0;
  bit          last_z = 0, last_o = 0, last_u = 0;
  int          last_lat = 0, last_vcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: what the result must be, from plain arithmetic on the inputs.
  function automatic res_t model(logic [23:0] m, logic c, logic [7:0] e);
    res_t   r;
    int     ee, lz, s;
    longint v;
    r.m = '0; r.e = '0; r.z = 0; r.o = 0; r.u = 0; r.lat = 2; r.acc = 0;
    if (c) begin
      ee = int'(e) + 1;
      if (ee >= 255) begin
        r.o = 1; r.e = 8'hFF; r.m = '0;
      end else begin
        v = (longint'(m) >> 1) + 64'h800000;
`ifdef NORM_ROUND_EN
        r.lat = 3;
        if (m[0] && v[0]) begin
          v = v + 1;
          if (v == 64'h1000000) begin
            v  = 64'h800000;
            ee = ee + 1;
          end
        end
`endif
        if (ee >= 255) begin
          r.o = 1; r.e = 8'hFF; r.m = '0;
        end else begin
          r.m = 24'(v); r.e = 8'(ee);
        end
      end
    end else if (m == 24'h0) begin
      r.z = 1;
    end else begin
      v = longint'(m); lz = 0;
      while (v < 64'h800000) begin
        v = v * 2; lz++;
      end
      if (lz == 0) begin
        r.m = m; r.e = e;
      end else if (int'(e) > lz) begin
        r.m = 24'(longint'(m) << lz); r.e = 8'(int'(e) - lz); r.lat = 2 + lz;
      end else begin
        s = (int'(e) > 1) ? int'(e) - 1 : 0;
        r.m = 24'(longint'(m) << s); r.e = '0; r.u = 1; r.lat = 3 + s;
      end
    end
    return r;
  endfunction

  // Output checker: runs every cycle, mid-way between active edges.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_done = 0;
      vcnt = 0;
    end else if (started) begin
      if (q.size() == 0) begin
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
      end else begin
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        if (out_valid) begin
          if (!in_done) begin
            first_lat = cyc - q[0].acc + 1;
            chk("latency", 32'(first_lat), 32'(q[0].lat));
            in_done = 1;
            vcnt = 0;
          end
          vcnt++;
          chk("out_mant", 32'(out_mant), 32'(q[0].m));
          chk("out_exp", 32'(out_exp), 32'(q[0].e));
          chk("out_zero", 32'(out_zero), 32'(q[0].z));
          chk("out_ovf", 32'(out_ovf), 32'(q[0].o));
          chk("out_unf", 32'(out_unf), 32'(q[0].u));
          if (out_ready) begin
            last_m = out_mant; last_e = out_exp;
            last_z = out_zero; last_o = out_ovf; last_u = out_unf;
            last_lat = first_lat; last_vcnt = vcnt;
            void'(q.pop_front());
            in_done = 0;
          end
        end
      end
    end
  end

  // Downstream back-pressure: random, or held low for hold_cnt cycles of out_valid.
  initial forever begin
    @(posedge clk);
    #2;
    if (out_valid && hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(logic [23:0] m, logic c, logic [7:0] e);
    res_t r;
    int   g;
    @(negedge clk);
    in_valid = 1'b1; in_mant = m; in_carry = c; in_exp = e;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    r = model(m, c, e);
    r.acc = cyc;
    q.push_back(r);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (q.size() != 0 && g < 150) begin
      @(negedge clk);
      g++;
    end
    chk("done_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
  endtask

  task automatic directed(string nm, logic [23:0] m, logic c, logic [7:0] e,
                          logic [23:0] xm, logic [7:0] xe, bit xz, bit xo, bit xu, int xl);
    res_t r;
    r = model(m, c, e);
    chk({nm, "_model_mant"}, 32'(r.m), 32'(xm));
    chk({nm, "_model_exp"}, 32'(r.e), 32'(xe));
    chk({nm, "_model_lat"}, 32'(r.lat), 32'(xl));
    send(m, c, e);
    wait_done();
    chk({nm, "_mant"}, 32'(last_m), 32'(xm));
    chk({nm, "_exp"}, 32'(last_e), 32'(xe));
    chk({nm, "_flags"}, 32'({last_z, last_o, last_u}), 32'({xz, xo, xu}));
    chk({nm, "_lat"}, 32'(last_lat), 32'(xl));
    $display("directed %s: mant=%06h exp=%02h z=%0d o=%0d u=%0d lat=%0d",
             nm, last_m, last_e, last_z, last_o, last_u, last_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] m;
    logic        c;
    logic [7:0]  e;
    int          kind;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_mant", 32'(out_mant), 32'd0);
    chk("reset_out_exp", 32'(out_exp), 32'd0);
    chk("reset_flags", 32'({out_zero, out_ovf, out_unf}), 32'd0);
    started = 1;

    directed("normalized", 24'h800000, 1'b0, 8'h7F, 24'h800000, 8'h7F, 0, 0, 0, 2);
`ifdef NORM_ROUND_EN
    directed("carry", 24'h000003, 1'b1, 8'h80, 24'h800002, 8'h81, 0, 0, 0, 3);
`else
    directed("carry", 24'h000003, 1'b1, 8'h80, 24'h800001, 8'h81, 0, 0, 0, 2);
`endif
    hold_cnt = 5;
    directed("shift15_hold", 24'h000100, 1'b0, 8'h7F, 24'h800000, 8'h70, 0, 0, 0, 17);
    chk("hold_valid_cycles", 32'(last_vcnt >= 6), 32'd1);
    directed("zero", 24'h000000, 1'b0, 8'h55, 24'h000000, 8'h00, 1, 0, 0, 2);
    directed("overflow", 24'h123456, 1'b1, 8'hFE, 24'h000000, 8'hFF, 0, 1, 0, 2);
    directed("underflow", 24'h000100, 1'b0, 8'h05, 24'h001000, 8'h00, 0, 0, 1, 7);
    directed("shift23", 24'h000001, 1'b0, 8'h80, 24'h800000, 8'h69, 0, 0, 0, 25);

    // Reset in the middle of a long shift: the word must vanish.
    send(24'h000001, 1'b0, 8'h80);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_mant", 32'(out_mant), 32'd0);
    repeat (4) @(posedge clk);
    directed("after_reset", 24'h000100, 1'b0, 8'h7F, 24'h800000, 8'h70, 0, 0, 0, 17);

    // Random words, back-to-back or with gaps, checked by the output checker.
    for (int i = 0; i < 250; i++) begin
      c = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 4);
      case (kind)
        0:       m = 24'($urandom);
        1:       m = 24'($urandom) >> $urandom_range(1, 23);
        2:       m = 24'h000000;
        3:       m = 24'h000001 << $urandom_range(0, 23);
        default: m = 24'hFFFFFF;
      endcase
      if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 6));
      else                           e = 8'($urandom_range(0, 255));
      if (c && $urandom_range(0, 4) == 0) e = 8'($urandom_range(250, 254));
      if (c && e == 8'hFF) e = 8'hFE;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(m, c, e);
      $display("rand %0d: mant=%06h carry=%0d exp=%02h", i, m, c, e);
    end
    wait_done();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mant_normalize.md
Name: fp_mant_normalize

Overview:
- Multi-cycle normalizer placed directly downstream of the 24-bit mantissa adder in the floating-point add path.
- Consumes the 24-bit sum, the adder carry-out and the operand exponent.
- Produces a normalized 24-bit mantissa (bit 23 set) with adjusted exponent, plus zero, overflow and underflow flags.
- Uses a valid/ready handshake on both sides and shifts left one bit per cycle.

Parameters:
- MANT_W, 24, mantissa/sum width; must match the adder width.
- EXP_W, 8, biased exponent width; EXP_MAX = 2**EXP_W-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers in_mant/in_carry/in_exp.
- in_ready  output  1  block accepts a word; high only in IDLE.
- in_mant  input  MANT_W  adder sum.
- in_carry  input  1  adder carry-out.
- in_exp  input  EXP_W  biased exponent of the larger operand.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  MANT_W  normalized mantissa.
- out_exp  output  EXP_W  adjusted biased exponent.
- out_zero  output  1  result is exact zero.
- out_ovf  output  1  exponent overflow; out_exp=EXP_MAX, out_mant=0.
- out_unf  output  1  underflow to exponent 0; mantissa left denormal.

Behaviour:
- Reset: state=IDLE; out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf all 0. in_ready=1 from the first cycle after reset. Reset mid-operation aborts the word; nothing is emitted.
- States: IDLE, CHECK, SHIFT, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid && in_ready, register mant/carry/exp and go to CHECK.
- CHECK, in priority order:
  - carry=1: mant={1,mant[23:1]}, exp+1. If exp+1==EXP_MAX: ovf=1, mant=0, exp=EXP_MAX. Go to DONE.
  - mant==0: zero=1, exp=0 → DONE.
  - mant[23]=1 → DONE, unchanged.
  - otherwise → SHIFT.
- SHIFT, per cycle:
  - If mant[23]=1 → DONE.
  - Else if exp>1: mant<<=1, exp-=1.
  - Else (exp<=1): unf=1, exp=0, mant unchanged → DONE.
  - Exponent never wraps below 0.
- DONE: out_valid=1. All outputs stay stable until out_ready=1, then IDLE on the next edge. out_valid and flags clear on leaving DONE. Simultaneous out_ready and a new in_valid: the new word is not accepted in that cycle (no overlap).
- Latency, accept edge T: out_valid at T+2 for carry/zero/already-normalized inputs; T+2+k for k left shifts; maximum T+2+23.
- Flags are mutually exclusive.

Optional Feature:
- Macro NORM_ROUND_EN.
- Defined: on the carry path, the bit dropped by the right shift is a guard bit, rounded to nearest-even (increment if dropped=1 and the new lsb=1). Rounding happens in an extra ROUND state, so the carry path takes +1 cycle. If the increment wraps the mantissa, mant=0x800000 and exp+1 again, with the same ovf check.
- Undefined: the dropped bit is truncated and there is no ROUND state.

Decomposition:
- Package fp_norm_pkg holds MANT_W, EXP_W, EXP_MAX and the state enum typedef (with ROUND under the macro).
- Single module; no sub-module is natural (iterative shift, no leading-zero counter).

Test Plan:
- in_mant=0x800000, carry=0, exp=0x7F → out_mant 0x800000, exp 0x7F, no flags, out_valid 2 cycles after accept.
- carry=1, mant=0x000003, exp=0x80 → without macro: 0x800001, exp 0x81; with NORM_ROUND_EN: 0x800002, exp 0x81, one cycle later.
- mant=0x000100, exp=0x7F → 0x800000, exp 0x70, out_valid at T+17. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
- mant=0 → out_zero=1, exp 0. carry=1, exp=0xFE → out_ovf=1, exp 0xFF, mant 0.
- mant=0x000100, exp=0x05 → out_unf=1, exp 0, mant 0x001000 after 4 shifts.
- Assert rst during SHIFT → no out_valid, in_ready=1 the next cycle; the following word processes normally.
